// File: rtl/sram_request_arbiter.sv
`default_nettype none
// ============================================================================
// sram_request_arbiter: arbitrates CPU/VGA/UART requests onto one Wishbone master;
// optional bus timeout abort via `define SRAM_ARB_TIMEOUT_EN. Revision: 1.0
// ============================================================================
module sram_request_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  req_i,
  input  logic [2:0]  we_i,
  input  logic [95:0] addr_i,
  input  logic [95:0] wdata_i,
  input  logic [11:0] sel_i,
  input  logic [1:0]  vga_state_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [1:0]  current_client_o,
  output logic [31:0] rdata_o,
  output logic [2:0]  ack_o,
  output logic [2:0]  busy_o,
  output logic [2:0]  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CLIENT_CPU  = 2'd0;
  localparam logic [1:0] CLIENT_VGA  = 2'd1;
  localparam logic [1:0] CLIENT_UART = 2'd2;
  localparam logic [1:0] CLIENT_NONE = 2'd3;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  client_q, client_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  ack_q, ack_d;
  logic        rr_uart_last_q, rr_uart_last_d;

  logic        grant_valid;
  logic [1:0]  grant_client;
  logic        grant_we;
  logic [31:0] grant_adr;
  logic [31:0] grant_dat;
  logic [3:0]  grant_sel;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [2:0]  err_q, err_d;
`endif

  // VGA always wins when eligible; CPU/UART only compete outside the active/pre-active frame.
  always_comb begin
    grant_valid  = 1'b0;
    grant_client = CLIENT_NONE;
    if (req_i[1]) begin
      grant_valid  = 1'b1;
      grant_client = CLIENT_VGA;
    end else if (vga_state_i == 2'd0 || vga_state_i == 2'd3) begin
      if (req_i[0] && req_i[2]) begin
        grant_valid  = 1'b1;
        grant_client = rr_uart_last_q ? CLIENT_CPU : CLIENT_UART;
      end else if (req_i[0]) begin
        grant_valid  = 1'b1;
        grant_client = CLIENT_CPU;
      end else if (req_i[2]) begin
        grant_valid  = 1'b1;
        grant_client = CLIENT_UART;
      end
    end
  end

  always_comb begin
    grant_we  = 1'b0;
    grant_adr = '0;
    grant_dat = '0;
    grant_sel = '0;
    case (grant_client)
      CLIENT_CPU: begin
        grant_we  = we_i[0];
        grant_adr = addr_i[31:0];
        grant_dat = wdata_i[31:0];
        grant_sel = sel_i[3:0];
      end
      CLIENT_VGA: begin
        grant_adr = addr_i[63:32];
        grant_dat = wdata_i[63:32];
        grant_sel = sel_i[7:4];
      end
      CLIENT_UART: begin
        grant_we  = we_i[2];
        grant_adr = addr_i[95:64];
        grant_dat = wdata_i[95:64];
        grant_sel = sel_i[11:8];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    client_d       = client_q;
    cyc_d          = cyc_q;
    we_d           = we_q;
    adr_d          = adr_q;
    dat_d          = dat_q;
    sel_d          = sel_q;
    rdata_d        = rdata_q;
    ack_d          = 3'b000;
    rr_uart_last_d = rr_uart_last_q;
`ifdef SRAM_ARB_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    err_d          = 3'b000;
`endif
    case (state_q)
      ST_IDLE: begin
        client_d = CLIENT_NONE;
        if (grant_valid) begin
          state_d  = ST_BUS;
          client_d = grant_client;
          cyc_d    = 1'b1;
          we_d     = grant_we;
          adr_d    = grant_adr;
          dat_d    = grant_dat;
          sel_d    = grant_sel;
          if (grant_client == CLIENT_CPU)  rr_uart_last_d = 1'b0;
          if (grant_client == CLIENT_UART) rr_uart_last_d = 1'b1;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          state_d  = ST_DONE;
          client_d = CLIENT_NONE;
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          rdata_d  = wb_dat_i;
          ack_d    = 3'b001 << client_q;
`ifdef SRAM_ARB_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
        end else if (tmo_cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          // Abort: release the bus without touching rdata.
          state_d   = ST_DONE;
          client_d  = CLIENT_NONE;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          err_d     = 3'b001 << client_q;
          tmo_cnt_d = 8'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        client_d = CLIENT_NONE;
      end
      default: begin
        state_d  = ST_IDLE;
        client_d = CLIENT_NONE;
        cyc_d    = 1'b0;
        we_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= ST_IDLE;
      client_q       <= CLIENT_NONE;
      cyc_q          <= 1'b0;
      we_q           <= 1'b0;
      adr_q          <= '0;
      dat_q          <= '0;
      sel_q          <= '0;
      rdata_q        <= '0;
      ack_q          <= '0;
      rr_uart_last_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      client_q       <= client_d;
      cyc_q          <= cyc_d;
      we_q           <= we_d;
      adr_q          <= adr_d;
      dat_q          <= dat_d;
      sel_q          <= sel_d;
      rdata_q        <= rdata_d;
      ack_q          <= ack_d;
      rr_uart_last_q <= rr_uart_last_d;
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 3'b000;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 3'b000;
`endif

  assign wb_cyc_o         = cyc_q;
  assign wb_stb_o         = cyc_q;
  assign wb_we_o          = we_q;
  assign wb_adr_o         = adr_q;
  assign wb_dat_o         = dat_q;
  assign wb_sel_o         = sel_q;
  assign current_client_o = client_q;
  assign rdata_o          = rdata_q;
  assign ack_o            = ack_q;
  assign busy_o           = req_i & ~ack_q;

  // VGA write enable is architecturally ignored; limit is unused without the timeout.
  logic unused_ok;
  assign unused_ok = ^{we_i[1], TIMEOUT_LIMIT};

endmodule
`default_nettype wire
